// File: rtl/sample_playback.sv
// Two-bank frame store fed by a valid/ready stream, replayed one sample per SAMPLE_PERIOD clocks.
// Malformed frames are discarded with a frame_err pulse; a dry reader raises sticky underrun.
module sample_playback #(
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned FRAME_LEN     = 18,
  parameter int unsigned SAMPLE_PERIOD = 557
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] in_data_i,
  input  logic                in_valid_i,
  input  logic                in_last_i,
  output logic                in_ready_o,
  output logic [SAMPLE_W-1:0] out_data_o,
  output logic                out_strobe_o,
  output logic                frame_start_o,
  output logic                frame_err_o,
  output logic                underrun_o,
  input  logic                underrun_clr_i
);

  localparam int unsigned IdxW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned TickW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(FRAME_LEN - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_PERIOD - 1);

  localparam logic [0:0] WrFill = 1'b0;
  localparam logic [0:0] WrDrop = 1'b1;
  localparam logic [0:0] RdIdle = 1'b0;
  localparam logic [0:0] RdPlay = 1'b1;

  logic [SAMPLE_W-1:0] mem_q [2][FRAME_LEN];

  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [IdxW-1:0]     wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]     rd_idx_q, rd_idx_d;
  logic [0:0]          wr_st_q, wr_st_d;
  logic [0:0]          rd_st_q, rd_st_d;
  logic                in_ready_q, in_ready_d;
  logic [SAMPLE_W-1:0] out_data_q, out_data_d;
  logic                out_strobe_q, out_strobe_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_err_q, frame_err_d;
  logic                underrun_q, underrun_d;

  logic tick, wr_xfer, wr_en, do_out, underrun_set;

  assign tick    = (tick_cnt_q == TickLast);
  assign wr_xfer = in_valid_i & in_ready_q;
  assign wr_en   = wr_xfer & (wr_st_q == WrFill);

  always_comb begin
    tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
    bank_full_d   = bank_full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    wr_st_d       = wr_st_q;
    rd_st_d       = rd_st_q;
    out_data_d    = out_data_q;
    out_strobe_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_err_d   = 1'b0;
    do_out        = 1'b0;
    underrun_set  = 1'b0;

    // Reader: rd_idx is always 0 while idle, so entering PLAY starts at sample 0.
    if (tick) begin
      if (bank_full_q[rd_bank_q]) begin
        rd_st_d = RdPlay;
        do_out  = 1'b1;
      end else if (rd_st_q == RdPlay) begin
        underrun_set = 1'b1;
        rd_st_d      = RdIdle;
      end
    end

    if (do_out) begin
      out_data_d    = mem_q[rd_bank_q][rd_idx_q];
      out_strobe_d  = 1'b1;
      frame_start_d = (rd_idx_q == '0);
      if (rd_idx_q == IdxLast) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
        rd_idx_d               = '0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end

    if (wr_xfer) begin
      unique case (wr_st_q)
        WrFill: begin
          if (in_last_i) begin
            wr_idx_d = '0;
            if (wr_idx_q == IdxLast) begin
              bank_full_d[wr_bank_q] = 1'b1;
              wr_bank_d              = ~wr_bank_q;
            end else begin
              frame_err_d = 1'b1;
            end
          end else if (wr_idx_q == IdxLast) begin
            wr_idx_d    = '0;
            frame_err_d = 1'b1;
            wr_st_d     = WrDrop;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
        WrDrop: begin
          if (in_last_i) wr_st_d = WrFill;
        end
      endcase
    end

    // Uses the registered full flags so a bank freed this cycle is offered one cycle later.
    in_ready_d = (wr_st_d == WrDrop) | ~bank_full_q[wr_bank_d];
    underrun_d = underrun_set | (underrun_q & ~underrun_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt_q    <= '0;
      bank_full_q   <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      wr_st_q       <= WrFill;
      rd_st_q       <= RdIdle;
      in_ready_q    <= 1'b0;
      out_data_q    <= '0;
      out_strobe_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_err_q   <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      bank_full_q   <= bank_full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      wr_st_q       <= wr_st_d;
      rd_st_q       <= rd_st_d;
      in_ready_q    <= in_ready_d;
      out_data_q    <= out_data_d;
      out_strobe_q  <= out_strobe_d;
      frame_start_q <= frame_start_d;
      frame_err_q   <= frame_err_d;
      underrun_q    <= underrun_d;
    end
  end

  // Sample storage needs no reset: the full flags gate every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_bank_q][wr_idx_q] <= in_data_i;
  end

  assign in_ready_o    = in_ready_q;
  assign out_data_o    = out_data_q;
  assign out_strobe_o  = out_strobe_q;
  assign frame_start_o = frame_start_q;
  assign frame_err_o   = frame_err_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_sample_playback.sv
// Randomised bench for sample_playback against a frame-queue reference model.
// The model tracks accepted frames and the playback cadence, not the bank/pointer encoding.
module tb_sample_playback;

  localparam int P = 8;
  localparam int L = 18;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_strobe;
  logic         frame_start;
  logic         frame_err;
  logic         underrun;
  logic         underrun_clr = 1'b0;

  always #5 clk = ~clk;

  sample_playback #(
    .SAMPLE_W     (W),
    .FRAME_LEN    (L),
    .SAMPLE_PERIOD(P)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_data_i     (in_data),
    .in_valid_i    (in_valid),
    .in_last_i     (in_last),
    .in_ready_o    (in_ready),
    .out_data_o    (out_data),
    .out_strobe_o  (out_strobe),
    .frame_start_o (frame_start),
    .frame_err_o   (frame_err),
    .underrun_o    (underrun),
    .underrun_clr_i(underrun_clr)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (written only by the monitor).
  logic [W-1:0] exp_q[$];
  logic [W-1:0] wbuf[$];
  bit           drop;
  int           avail;
  int           pos;
  bit           playing;
  bit           exp_ur;
  logic [W-1:0] exp_out;
  int           cyc;
  int           strobe_cnt = 0;
  int           err_cnt = 0;
  int           end_cnt = 0;
  int           last_end_cyc = 0;

  function automatic void model_reset();
    exp_q.delete();
    wbuf.delete();
    drop    = 1'b0;
    avail   = 0;
    pos     = 0;
    playing = 1'b0;
    exp_ur  = 1'b0;
    exp_out = '0;
    cyc     = 0;
  endfunction

  initial begin
    logic [W-1:0] c_d;
    bit c_v, c_r, c_l, c_clr, e_strobe, e_start, e_err, freed, ur_set, e_rdy;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        continue;
      end
      c_v = in_valid; c_r = in_ready; c_l = in_last; c_d = in_data; c_clr = underrun_clr;
      @(posedge clk);
      #1;
      if (rst) continue;
      cyc++;
      e_strobe = 0; e_start = 0; e_err = 0; freed = 0; ur_set = 0;
      // Playback: one sample per period, counted from reset release.
      if (cyc % P == 0) begin
        if (pos == 0 && avail == 0) begin
          if (playing) begin
            ur_set  = 1;
            playing = 0;
          end
        end else begin
          e_strobe = 1;
          e_start  = (pos == 0);
          playing  = 1;
          exp_out  = exp_q.pop_front();
          pos++;
          if (pos == L) begin
            pos = 0;
            avail--;
            freed = 1;
            last_end_cyc = cyc;
            end_cnt++;
          end
        end
      end
      // Frame acceptance: exactly L words with last on the final one.
      if (c_v && c_r) begin
        if (drop) begin
          if (c_l) drop = 0;
        end else begin
          wbuf.push_back(c_d);
          if (c_l) begin
            if (wbuf.size() == L) begin
              foreach (wbuf[i]) exp_q.push_back(wbuf[i]);
              avail++;
            end else begin
              e_err = 1;
            end
            wbuf.delete();
          end else if (wbuf.size() == L) begin
            e_err = 1;
            wbuf.delete();
            drop = 1;
          end
        end
      end
      exp_ur = ur_set ? 1'b1 : (c_clr ? 1'b0 : exp_ur);
      e_rdy  = drop || ((avail + int'(freed)) < 2);
      if (out_strobe) strobe_cnt++;
      if (frame_err) err_cnt++;
      check_eq("out_strobe", 32'(out_strobe), 32'(e_strobe));
      check_eq("frame_start", 32'(frame_start), 32'(e_start));
      check_eq("out_data", 32'(out_data), 32'(exp_out));
      check_eq("frame_err", 32'(frame_err), 32'(e_err));
      check_eq("in_ready", 32'(in_ready), 32'(e_rdy));
      check_eq("underrun", 32'(underrun), 32'(exp_ur));
    end
  end

  // Driver: inputs change 2 time units after each rising edge.
  bit rand_clr = 1'b0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit last);
    bit r;
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      underrun_clr = rand_clr && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      r = in_ready;
      step();
      if (r) break;
      t++;
      if (t > 3000) begin
        check_eq("ready_timeout", 32'(r), 32'd1);
        break;
      end
    end
    underrun_clr = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n, input bit last_at_end, input bit rnd);
    for (int i = 0; i < n; i++) begin
      send_word(rnd ? W'($urandom) : W'(base + i), last_at_end && (i == n - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    #1;
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    step();
  endtask

  task automatic pulse_clr();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
  endtask

  initial begin
    int s0, e0, t, gap, kind;
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_out_data", 32'(out_data), 32'd0);
    check_eq("init_in_ready", 32'(in_ready), 32'd0);
    check_eq("init_strobe", 32'(out_strobe), 32'd0);
    #2 rst = 1'b0;
    step();

    // T1: single frame, then underrun with output holding the last sample.
    s0 = strobe_cnt;
    send_frame(0, L, 1, 0);
    wait_idle(200);
    check_eq("t1_strobes", 32'(strobe_cnt - s0), 32'(L));
    check_eq("t1_underrun", 32'(underrun), 32'd1);
    check_eq("t1_hold", 32'(out_data), 32'd17);

    // T6a: clear the sticky flag.
    pulse_clr();
    check_eq("t6_clr", 32'(underrun), 32'd0);

    // T2: two frames back-to-back, writer stalls while both banks are full.
    s0 = strobe_cnt;
    send_frame(100, L, 1, 0);
    send_frame(200, L, 1, 0);
    check_eq("t2_stall", 32'(in_ready), 32'd0);
    check_eq("t2_no_ur", 32'(underrun), 32'd0);
    wait_idle(320);
    check_eq("t2_strobes", 32'(strobe_cnt - s0), 32'(2 * L));
    check_eq("t2_last", 32'(out_data), 32'd217);

    // T3: short frame is rejected, following frame plays.
    e0 = err_cnt;
    s0 = strobe_cnt;
    send_frame(50, 5, 1, 0);
    wait_idle(3);
    check_eq("t3_err", 32'(err_cnt - e0), 32'd1);
    send_frame(0, L, 1, 0);
    wait_idle(200);
    check_eq("t3_strobes", 32'(strobe_cnt - s0), 32'(L));

    // T4: long frame dropped in full, including the tail up to in_last.
    e0 = err_cnt;
    s0 = strobe_cnt;
    send_frame(300, 20, 0, 0);
    send_frame(400, 3, 1, 0);
    wait_idle(3);
    check_eq("t4_err", 32'(err_cnt - e0), 32'd1);
    check_eq("t4_ready", 32'(in_ready), 32'd1);
    wait_idle(200);
    check_eq("t4_strobes", 32'(strobe_cnt - s0), 32'd0);

    // T5: reset during playback, then a fresh frame from sample 0.
    send_frame(500, L, 1, 0);
    t = 0;
    while (out_data != W'(509) && t < 400) begin
      step();
      t++;
    end
    check_eq("t5_reach9", 32'(out_data), 32'd509);
    do_reset();
    s0 = strobe_cnt;
    send_frame(600, L, 1, 0);
    wait_idle(200);
    check_eq("t5_strobes", 32'(strobe_cnt - s0), 32'(L));
    check_eq("t5_last", 32'(out_data), 32'd617);

    // T6b: clear arriving on the same cycle the underrun is raised.
    pulse_clr();
    check_eq("t6_clr2", 32'(underrun), 32'd0);
    e0 = end_cnt;
    send_frame(700, L, 1, 0);
    t = 0;
    while (end_cnt == e0 && t < 400) begin
      step();
      t++;
    end
    check_eq("t6_end_seen", 32'(end_cnt - e0), 32'd1);
    repeat (7) step();
    check_eq("t6_align", 32'(cyc), 32'(last_end_cyc + 7));
    pulse_clr();
    check_eq("t6_setwins", 32'(underrun), 32'd1);

    // Random traffic: mixed frame kinds, random gaps and clears.
    rand_clr = 1'b1;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) send_frame(0, $urandom_range(1, L - 1), 1, 1);
      else if (kind == 1) send_frame(0, $urandom_range(L + 1, L + 6), 1, 1);
      else send_frame(0, L, 1, 1);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 300) : $urandom_range(0, 4);
      wait_idle(gap);
    end
    rand_clr = 1'b0;
    wait_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
